// File: rtl/if_id_buffer.sv
`default_nettype none
// ============================================================================
// Module   : if_id_buffer
// Purpose  : IF/ID decoupling FIFO holding {instruction, PC, PC+4} per fetch.
//            Optional macro IF_ID_PERF_COUNTERS_EN adds stall/bubble/flush counters.
// Revision : 1.0  initial release
// ============================================================================
module if_id_buffer #(
    parameter int DEPTH       = 2,
    parameter int INSTR_WIDTH = 32,
    parameter int PC_WIDTH    = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] instruction_in,
    input  logic [PC_WIDTH-1:0]    PC_in,
    input  logic [PC_WIDTH-1:0]    PC_branch_link_in,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] instruction_out,
    output logic [PC_WIDTH-1:0]    PC_out,
    output logic [PC_WIDTH-1:0]    PC_branch_link_out
`ifdef IF_ID_PERF_COUNTERS_EN
    ,
    output logic [31:0]            stall_cycles,
    output logic [31:0]            bubble_cycles,
    output logic [31:0]            flush_count
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]       C_FULL = CNT_W'(DEPTH);
    localparam logic [INSTR_WIDTH-1:0] C_NOP  = INSTR_WIDTH'(32'hD503201F);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
    logic [PC_WIDTH-1:0]    pc_mem    [DEPTH];
    logic [PC_WIDTH-1:0]    link_mem  [DEPTH];

    logic w_push;
    logic w_pop;

    // Ready depends only on occupancy, so a full buffer refuses even when popping.
    assign in_ready  = (count_q != C_FULL);
    assign out_valid = (count_q != '0);
    assign w_push    = in_valid & in_ready & ~flush;
    assign w_pop     = out_valid & out_ready & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; occupancy alone qualifies it.
    always_ff @(posedge clock) begin
        if (w_push) begin
            instr_mem[wr_ptr_q] <= instruction_in;
            pc_mem[wr_ptr_q]    <= PC_in;
            link_mem[wr_ptr_q]  <= PC_branch_link_in;
        end
    end

    always_comb begin
        instruction_out    = C_NOP;
        PC_out             = '0;
        PC_branch_link_out = '0;
        if (out_valid) begin
            instruction_out    = instr_mem[rd_ptr_q];
            PC_out             = pc_mem[rd_ptr_q];
            PC_branch_link_out = link_mem[rd_ptr_q];
        end
    end

`ifdef IF_ID_PERF_COUNTERS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] bubble_cycles_q, bubble_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        stall_cycles_d  = stall_cycles_q;
        bubble_cycles_d = bubble_cycles_q;
        flush_count_d   = flush_count_q;
        if (in_valid && !in_ready && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (!out_valid && out_ready && (bubble_cycles_q != 32'hFFFF_FFFF)) begin
            bubble_cycles_d = bubble_cycles_q + 32'd1;
        end
        if (flush && (flush_count_q != 32'hFFFF_FFFF)) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles_q  <= '0;
            bubble_cycles_q <= '0;
            flush_count_q   <= '0;
        end else begin
            stall_cycles_q  <= stall_cycles_d;
            bubble_cycles_q <= bubble_cycles_d;
            flush_count_q   <= flush_count_d;
        end
    end

    assign stall_cycles  = stall_cycles_q;
    assign bubble_cycles = bubble_cycles_q;
    assign flush_count   = flush_count_q;
`endif

endmodule
`default_nettype wire
